mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_pkg.sv | 36 +++
 rtl/mem_wb_stage_watchdog.sv | 27 ++
 rtl/mem_wb_stage.sv | 149 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings and widths for the MEM/WB stage and its watchdog.
package mem_wb_stage_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned REG_AW        = 5;
  localparam int unsigned WD_W          = 8;
  localparam int unsigned TIMEOUT_LIMIT = 255;

  typedef enum logic [1:0] {
    COND_FLUSH = 2'd0,
    COND_LOAD  = 2'd1,
    COND_HOLD  = 2'd2
  } cond_e;

  typedef enum logic [1:0] {
    MTR_ALU = 2'd0,
    MTR_MEM = 2'd1,
    MTR_PC  = 2'd2
  } memtoreg_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // MEM/WB pipeline register payload
  typedef struct packed {
    logic [1:0]        memtoreg;
    logic              regwrite;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   memdata;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   pc;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_watchdog.sv
// Wait-state cycle counter; expired_c flags the cycle that completes TIMEOUT_LIMIT WAIT cycles.
module mem_watchdog
  import mem_wb_stage_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  output logic expired_c
);

  logic [WD_W-1:0] cnt_q;

  // cnt_q + 1 is the number of WAIT cycles including the current one
  assign expired_c = active && (WD_W'(cnt_q + WD_W'(1)) == WD_W'(TIMEOUT_LIMIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (active && !expired_c) begin
      cnt_q <= cnt_q + WD_W'(1);
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: data-memory access FSM plus MEM/WB output register.
// Optional wait-state timeout enabled by defining MEM_TIMEOUT_EN.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        condition,
  input  logic [1:0]        memtoreg,
  input  logic              memwrite,
  input  logic              memread,
  input  logic              regwrite,
  input  logic [XLEN-1:0]   ALUresult,
  input  logic [XLEN-1:0]   Readdata2,
  input  logic [REG_AW-1:0] Regwriteaddress,
  input  logic [XLEN-1:0]   PCin,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              mem_stall,
  output logic              mem_error,
  output logic [1:0]        memtoregout,
  output logic              regwriteout,
  output logic [XLEN-1:0]   ALUresultout,
  output logic [XLEN-1:0]   Memdataout,
  output logic [REG_AW-1:0] Regwriteaddressout,
  output logic [XLEN-1:0]   PCout
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic            we_q;
  logic            flush_q;
  mem_wb_t         wb_q, wb_d, load_c;

  logic access, aligned, pending, misaligned, in_wait, enter_wait, stall_raw, timeout_c;

  assign access     = memread | memwrite;
  assign aligned    = (ALUresult[1:0] == 2'b00);
  assign in_wait    = (state_q == ST_WAIT);
  assign pending    = !in_wait && access && aligned;
  assign misaligned = !in_wait && access && !aligned;
  assign enter_wait = pending && !dmem_ready;
  assign stall_raw  = (pending || in_wait) && !dmem_ready;

`ifdef MEM_TIMEOUT_EN
  mem_watchdog u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .start     (enter_wait),
    .active    (in_wait),
    .expired_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Stall is forced low while reset is asserted, even with a pending request on the inputs
  assign mem_stall = reset && stall_raw && !timeout_c;

  // Bus drive: live inputs on the first cycle, latched copy while waiting
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    if (reset) begin
      if (in_wait) begin
        dmem_req   = 1'b1;
        dmem_we    = we_q;
        dmem_addr  = addr_q;
        dmem_wdata = wdata_q;
      end else if (pending) begin
        dmem_req   = 1'b1;
        dmem_we    = memwrite;
        dmem_addr  = ALUresult;
        dmem_wdata = Readdata2;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enter_wait) state_d = ST_WAIT;
      ST_WAIT: if (dmem_ready || timeout_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register next value; a flush seen during WAIT turns the completion into a bubble
  always_comb begin
    load_c.memtoreg = memtoreg;
    load_c.regwrite = regwrite;
    load_c.alu      = ALUresult;
    load_c.memdata  = memread ? dmem_rdata : '0;
    load_c.rd       = Regwriteaddress;
    load_c.pc       = PCin;
    wb_d            = wb_q;
    if (stall_raw || (in_wait && flush_q)) begin
      wb_d = '0;
    end else begin
      case (condition)
        COND_LOAD:  wb_d = misaligned ? '0 : load_c;
        COND_FLUSH: wb_d = '0;
        default:    wb_d = wb_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      flush_q   <= 1'b0;
      wb_q      <= '0;
      mem_error <= 1'b0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
      if (enter_wait) begin
        addr_q  <= ALUresult;
        wdata_q <= Readdata2;
        we_q    <= memwrite;
      end
      if (state_d == ST_IDLE) begin
        flush_q <= 1'b0;
      end else if (condition == COND_FLUSH) begin
        flush_q <= 1'b1;
      end
      if (misaligned || timeout_c) begin
        mem_error <= 1'b1;
      end
    end
  end

  assign memtoregout        = wb_q.memtoreg;
  assign regwriteout        = wb_q.regwrite;
  assign ALUresultout       = wb_q.alu;
  assign Memdataout         = wb_q.memdata;
  assign Regwriteaddressout = wb_q.rd;
  assign PCout              = wb_q.pc;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (timeout check adapts to MEM_TIMEOUT_EN).
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  condition, memtoreg;
  logic        memwrite, memread, regwrite, dmem_ready;
  logic [31:0] ALUresult, Readdata2, PCin, dmem_rdata;
  logic [4:0]  Regwriteaddress;
  logic        dmem_req, dmem_we, mem_stall, mem_error, regwriteout;
  logic [31:0] dmem_addr, dmem_wdata, ALUresultout, Memdataout, PCout;
  logic [1:0]  memtoregout;
  logic [4:0]  Regwriteaddressout;

  int n_checks = 0;
  int n_fail   = 0;
  int rel;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .condition(condition), .memtoreg(memtoreg),
    .memwrite(memwrite), .memread(memread), .regwrite(regwrite),
    .ALUresult(ALUresult), .Readdata2(Readdata2), .Regwriteaddress(Regwriteaddress),
    .PCin(PCin), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_error(mem_error), .memtoregout(memtoregout),
    .regwriteout(regwriteout), .ALUresultout(ALUresultout), .Memdataout(Memdataout),
    .Regwriteaddressout(Regwriteaddressout), .PCout(PCout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] cond, input logic mr, input logic mw, input logic rw,
                       input logic [1:0] mtr, input logic [31:0] alu, input logic [31:0] rd2,
                       input logic [4:0] rd, input logic [31:0] pc, input logic rdy,
                       input logic [31:0] rdata);
    condition = cond; memread = mr; memwrite = mw; regwrite = rw; memtoreg = mtr;
    ALUresult = alu; Readdata2 = rd2; Regwriteaddress = rd; PCin = pc;
    dmem_ready = rdy; dmem_rdata = rdata;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    // pending-looking inputs while in reset must not raise req/stall
    drive(2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 32'h100, 32'h0, 5'd1, 32'h0, 1'b0, 32'h0);
    #10;
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_err", 32'(mem_error), 32'h0);
    chk("rst_alu", ALUresultout, 32'h0);
    chk("rst_rw", 32'(regwriteout), 32'h0);
    drive(2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
    reset = 1'b1;
    tick();

    // zero-wait load
    drive(2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 32'h100, 32'h0, 5'd5, 32'h400, 1'b1, 32'hDEADBEEF);
    chk("zw_req", 32'(dmem_req), 32'h1);
    chk("zw_we", 32'(dmem_we), 32'h0);
    chk("zw_addr", dmem_addr, 32'h100);
    chk("zw_stall", 32'(mem_stall), 32'h0);
    tick();
    chk("zw_mdata", Memdataout, 32'hDEADBEEF);
    chk("zw_rw", 32'(regwriteout), 32'h1);
    chk("zw_mtr", 32'(memtoregout), 32'h1);
    chk("zw_rd", 32'(Regwriteaddressout), 32'h5);
    chk("zw_pc", PCout, 32'h400);

    // hold
    drive(2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h999, 32'h0, 5'd9, 32'h0, 1'b1, 32'h0);
    chk("hold_req", 32'(dmem_req), 32'h0);
    tick();
    chk("hold_alu", ALUresultout, 32'h100);
    chk("hold_mdata", Memdataout, 32'hDEADBEEF);
    // condition 3 behaves as hold
    drive(2'd3, 1'b0, 1'b0, 1'b0, 2'd0, 32'h999, 32'h0, 5'd9, 32'h0, 1'b1, 32'h0);
    tick();
    chk("hold3_pc", PCout, 32'h400);

    // ALU op: no memory data
    drive(2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h1234, 32'h0, 5'd7, 32'h404, 1'b1, 32'hDEADBEEF);
    tick();
    chk("alu_res", ALUresultout, 32'h1234);
    chk("alu_mdata", Memdataout, 32'h0);
    chk("alu_rd", 32'(Regwriteaddressout), 32'h7);

    // wait-state store, ready low for 3 cycles
    drive(2'd1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h20, 32'h55, 5'd0, 32'h408, 1'b0, 32'h0);
    chk("ws_req", 32'(dmem_req), 32'h1);
    chk("ws_we", 32'(dmem_we), 32'h1);
    chk("ws_addr0", dmem_addr, 32'h20);
    chk("ws_wdata0", dmem_wdata, 32'h55);
    chk("ws_stall1", 32'(mem_stall), 32'h1);
    tick();
    chk("ws_bub1", PCout, 32'h0);
    Readdata2 = 32'hAA;
    #1;
    chk("ws_wdata_latched", dmem_wdata, 32'h55);
    chk("ws_addr1", dmem_addr, 32'h20);
    chk("ws_stall2", 32'(mem_stall), 32'h1);
    tick();
    chk("ws_bub2", ALUresultout, 32'h0);
    chk("ws_stall3", 32'(mem_stall), 32'h1);
    tick();
    chk("ws_bub3_rw", 32'(regwriteout), 32'h0);
    chk("ws_bub3_pc", PCout, 32'h0);
    dmem_ready = 1'b1;
    #1;
    chk("ws_done_stall", 32'(mem_stall), 32'h0);
    chk("ws_done_req", 32'(dmem_req), 32'h1);
    chk("ws_done_addr", dmem_addr, 32'h20);
    tick();
    drive(2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h0);
    chk("ws_out_alu", ALUresultout, 32'h20);
    chk("ws_out_pc", PCout, 32'h408);
    chk("ws_out_rw", 32'(regwriteout), 32'h0);
    chk("ws_idle_req", 32'(dmem_req), 32'h0);

    // flush during WAIT: access completes, result becomes a bubble
    drive(2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 32'h40, 32'h0, 5'd3, 32'h500, 1'b0, 32'h0);
    tick();
    condition = 2'd0;
    #1;
    chk("fw_req", 32'(dmem_req), 32'h1);
    tick();
    condition = 2'd1; dmem_ready = 1'b1; dmem_rdata = 32'h12345678;
    #1;
    chk("fw_stall", 32'(mem_stall), 32'h0);
    tick();
    drive(2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h0);
    chk("fw_bub_rw", 32'(regwriteout), 32'h0);
    chk("fw_bub_mdata", Memdataout, 32'h0);
    chk("fw_bub_pc", PCout, 32'h0);

    // load then flush
    drive(2'd1, 1'b0, 1'b0, 1'b1, 2'd2, 32'hABC, 32'h0, 5'd4, 32'h600, 1'b1, 32'h0);
    tick();
    chk("fl_pre", ALUresultout, 32'hABC);
    condition = 2'd0;
    tick();
    chk("fl_alu", ALUresultout, 32'h0);
    chk("fl_pc", PCout, 32'h0);
    chk("fl_mtr", 32'(memtoregout), 32'h0);
    chk("fl_rw", 32'(regwriteout), 32'h0);

    // misaligned load after a valid load
    drive(2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 32'hDEF, 32'h0, 5'd6, 32'h604, 1'b1, 32'h0);
    tick();
    chk("ma_pre", ALUresultout, 32'hDEF);
    drive(2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 32'h102, 32'h0, 5'd6, 32'h700, 1'b0, 32'h0);
    chk("ma_req", 32'(dmem_req), 32'h0);
    chk("ma_stall", 32'(mem_stall), 32'h0);
    tick();
    chk("ma_err", 32'(mem_error), 32'h1);
    chk("ma_bub_alu", ALUresultout, 32'h0);
    chk("ma_bub_rw", 32'(regwriteout), 32'h0);
    drive(2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h10, 32'h0, 5'd2, 32'h704, 1'b1, 32'h0);
    tick();
    tick();
    chk("ma_sticky", 32'(mem_error), 32'h1);
    chk("ma_after_alu", ALUresultout, 32'h10);

    // reset in the middle of WAIT
    drive(2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 32'h80, 32'h0, 5'd8, 32'h800, 1'b0, 32'h0);
    tick();
    chk("rw_req", 32'(dmem_req), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("rw_req0", 32'(dmem_req), 32'h0);
    chk("rw_stall0", 32'(mem_stall), 32'h0);
    chk("rw_err0", 32'(mem_error), 32'h0);
    chk("rw_alu0", ALUresultout, 32'h0);
    memread = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    drive(2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 32'h84, 32'h0, 5'd8, 32'h804, 1'b1, 32'h0);
    chk("rw_idle_addr", dmem_addr, 32'h84);
    tick();

    // ready held low: stall persists (or releases at the 255th WAIT cycle with the timeout)
    drive(2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 32'h88, 32'h0, 5'd8, 32'h808, 1'b0, 32'h0);
    chk("to_stall0", 32'(mem_stall), 32'h1);
    tick();
    rel = 0;
    for (int k = 1; k <= 300; k++) begin
      #1;
      if (!mem_stall && rel == 0) rel = k;
      tick();
    end
`ifdef MEM_TIMEOUT_EN
    chk("to_release", 32'(rel), 32'd255);
    chk("to_err", 32'(mem_error), 32'h1);
`else
    chk("to_none", 32'(rel), 32'd0);
    chk("to_err", 32'(mem_error), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
